adder_column: RTL and testbench
===============================

Name: adder_column

Overview:
- Column of NUM_ROWS unsigned adder cells in the ViT accelerator datapath.
- Each row's input is masked by a per-row `visible` bit, then optionally added to the running sum of the row below (lower index) when that row's `adder_en` bit is set.
- All row results are registered and leave as one packed bus.
- Sits below a processing-element column and performs per-column partial-sum merging.

Parameters:
- DATA_WIDTH, 8, width of each row's operand and result (unsigned).
- NUM_ROWS, 4, number of rows/cells in the column; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- col_data_in  input  NUM_ROWS*DATA_WIDTH  packed row operands; row i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- adder_en  input  NUM_ROWS  bit i=1: row i adds the chained sum of row i-1.
- visible  input  NUM_ROWS  bit i=1: row i operand is used; 0: operand forced to 0.
- result  output  NUM_ROWS*DATA_WIDTH  registered per-row results, same packing as col_data_in.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst).
- Masking:
  - m[i] = visible[i] ? d[i] : 0, where d[i] is row i of col_data_in.
- Chain, combinational within one cycle, ripples from row 0 upward:
  - s[0] = m[0]; adder_en[0] is ignored because there is no row below.
  - For i >= 1: s[i] = adder_en[i] ? (s[i-1] + m[i]) : m[i].
- Arithmetic:
  - Unsigned, DATA_WIDTH bits.
  - Default is modulo 2^DATA_WIDTH wrap-around; carry out is discarded.
- Output register:
  - result row i <= s[i] on every rising clk edge.
  - No enable or hold: the register tracks the inputs every cycle.
- Latency: exactly 1 cycle from input change to result; throughput 1 vector per cycle.
- Reset:
  - rst low clears all result rows to 0 immediately, with no clock needed.
  - On rst release, the first rising edge loads s[].
  - Reset asserted mid-stream discards the in-flight value.
- Boundaries:
  - Row with visible=0 and adder_en=1 passes s[i-1] through unchanged, since m[i]=0.
  - Row with adder_en=0 breaks the chain; rows above it see only its own m[i] as their s[i-1].
  - All-zero adder_en: result row i = m[i].
  - All-zero visible: result = 0.
- Inputs X while rst low: result stays 0.

Optional Feature:
- Macro: ADDER_COLUMN_SAT_EN.
- Defined: each chained addition saturates to 2^DATA_WIDTH-1 on carry out.
  - Saturation applies per stage, so a saturated s[i-1] propagates upward.
- Undefined: wrap-around arithmetic as above.
- Port list and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - default DATA_WIDTH / NUM_ROWS constants;
  - a row-word typedef (logic [DATA_WIDTH-1:0]);
  - the saturation max constant.
- One sub-module, adder_column_cell:
  - inputs d, visible, adder_en, sum_in;
  - output sum_out (combinational; wrap or saturate per the macro).
- adder_column instantiates NUM_ROWS cells via generate, ties cell 0's sum_in to 0, and registers every sum_out.

Test Plan:
- Reset: rst=0 with random inputs and clk running -> result=0 throughout; after rst=1, first edge loads s[].
- Mixed mask/chain:
  - Stimulus: rows 3..0 = {125,230,25,30}, adder_en = 4'b0010, visible = 4'b1011.
  - Response: one cycle later result rows 3..0 = {125,0,55,30}, held while inputs are held.
- Full chain:
  - Stimulus: data {10,20,30,40}, adder_en = 4'b1110, visible = 4'b1111.
  - Response: result {100,90,70,40}.
- Pass-through of an invisible row:
  - Stimulus: data {5,99,7,3}, adder_en = 4'b1110, visible = 4'b1011.
  - Response: result {15,10,10,3}.
- Overflow:
  - Stimulus: data {0,0,230,30}, adder_en = 4'b0010, visible = 4'b0011.
  - Response: row1 = 4 (wrap) without the macro; row1 = 255 with ADDER_COLUMN_SAT_EN.
- Clear: all inputs 0 after activity -> result 0 on the next edge; a mid-stream rst=0 pulse zeroes result asynchronously.

Source files
------------

// File: rtl/adder_column_pkg.sv
// Shared constants and types for the adder column: default geometry, row word, saturation ceiling.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_column_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_ROWS   = 4;

  // One row operand/result at the default width.
  typedef logic [DEFAULT_DATA_WIDTH-1:0] row_t;

  // Ceiling a chained sum clamps to when saturation is built in.
  localparam row_t ROW_SAT_MAX = {DEFAULT_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/adder_column_cell.sv
// One adder cell: masks its operand with visible and optionally adds the chained sum from below.
// Latency: combinational (0 cycles); registering happens in adder_column.
// Backpressure: none; ADDER_COLUMN_SAT_EN selects saturating instead of wrapping addition.
module adder_column_cell
  import adder_column_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  visible,
  input  logic                  adder_en,
  input  logic [DATA_WIDTH-1:0] sum_in,
  output logic [DATA_WIDTH-1:0] sum_out
);

  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] chained;

`ifdef ADDER_COLUMN_SAT_EN
  // Widened sum exposes the carry so the stage can clamp to all-ones.
  logic [DATA_WIDTH:0] wide;

  always_comb begin
    m       = visible ? d : '0;
    wide    = {1'b0, sum_in} + {1'b0, m};
    chained = wide[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide[DATA_WIDTH-1:0];
    sum_out = adder_en ? chained : m;
  end
`else
  // Plain modulo-2^DATA_WIDTH addition; carry out is dropped.
  always_comb begin
    m       = visible ? d : '0;
    chained = sum_in + m;
    sum_out = adder_en ? chained : m;
  end
`endif

endmodule

// File: rtl/adder_column.sv
// Column of NUM_ROWS masked, chainable unsigned adders with every row result registered.
// Latency: 1 cycle input to result, 1 vector/cycle; async active-low reset clears result.
// Backpressure: none, output tracks inputs every cycle; ADDER_COLUMN_SAT_EN selects saturation.
module adder_column
  import adder_column_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_ROWS   = DEFAULT_NUM_ROWS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] col_data_in,
  input  logic [NUM_ROWS-1:0]            adder_en,
  input  logic [NUM_ROWS-1:0]            visible,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0]          s [NUM_ROWS];
  logic [NUM_ROWS*DATA_WIDTH-1:0] result_d;
  logic [NUM_ROWS*DATA_WIDTH-1:0] result_q;

  // Ripple chain: row 0 has nothing below, so its chained input is zero.
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    logic [DATA_WIDTH-1:0] sum_in;
    if (i == 0) begin : g_base
      assign sum_in = '0;
    end else begin : g_link
      assign sum_in = s[i-1];
    end

    adder_column_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .d        (col_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .visible  (visible[i]),
      .adder_en (adder_en[i]),
      .sum_in   (sum_in),
      .sum_out  (s[i])
    );
  end

  // Pack per-row chain outputs into the result bus layout.
  always_comb begin
    result_d = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      result_d[i*DATA_WIDTH +: DATA_WIDTH] = s[i];
    end
  end

  // Result register: loads every edge, cleared immediately while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_adder_column.sv
// Directed self-checking bench for adder_column at the default 8-bit x 4-row geometry.
// Latency: checks results #1 after the edge that loads them.
// Backpressure: n/a; define ADDER_COLUMN_SAT_EN to check the saturating build.
module tb_adder_column;

  localparam int DW = 8;
  localparam int NR = 4;

  logic              clk;
  logic              rst;
  logic [NR*DW-1:0]  col_data_in;
  logic [NR-1:0]     adder_en;
  logic [NR-1:0]     visible;
  logic [NR*DW-1:0]  result;

  int compared;
  int mismatched;

  adder_column #(
    .DATA_WIDTH (DW),
    .NUM_ROWS   (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_data_in (col_data_in),
    .adder_en    (adder_en),
    .visible     (visible),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [NR*DW-1:0] data, input logic [NR-1:0] en,
                       input logic [NR-1:0] vis);
    col_data_in = data;
    adder_en    = en;
    visible     = vis;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NR*DW-1:0] exp;
    rst = 1'b0;
    #1;
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL reset_async: result=%h required=%h", result, 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      drive($urandom, 4'($urandom), 4'($urandom));
      next_edge();
      compared++;
      if (result !== '0) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: result=%h required=%h", c, result, 32'h0);
      end
    end
    drive({8'd10, 8'd20, 8'd30, 8'd40}, 4'b1110, 4'b1111);
    rst = 1'b1;
    #2;
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL reset_release_no_edge: result=%h required=%h", result, 32'h0);
    end
    next_edge();
    exp = {8'd100, 8'd90, 8'd70, 8'd40};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL reset_first_load: result=%h required=%h", result, exp);
    end
  endtask

  task automatic test_mixed();
    logic [NR*DW-1:0] exp;
    exp = {8'd125, 8'd0, 8'd55, 8'd30};
    drive({8'd125, 8'd230, 8'd25, 8'd30}, 4'b0010, 4'b1011);
    #1;
    compared++;
    if (result === exp) begin
      mismatched++;
      $display("FAIL mixed_latency: result=%h changed before the edge", result);
    end
    for (int c = 0; c < 3; c++) begin
      next_edge();
      compared++;
      if (result !== exp) begin
        mismatched++;
        $display("FAIL mixed[%0d]: result=%h required=%h", c, result, exp);
      end
    end
  endtask

  task automatic test_full_chain();
    logic [NR*DW-1:0] exp;
    drive({8'd10, 8'd20, 8'd30, 8'd40}, 4'b1110, 4'b1111);
    next_edge();
    exp = {8'd100, 8'd90, 8'd70, 8'd40};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL full_chain: result=%h required=%h", result, exp);
    end
  endtask

  task automatic test_pass_through();
    logic [NR*DW-1:0] exp;
    drive({8'd5, 8'd99, 8'd7, 8'd3}, 4'b1110, 4'b1011);
    next_edge();
    exp = {8'd15, 8'd10, 8'd10, 8'd3};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL pass_through: result=%h required=%h", result, exp);
    end
  endtask

  task automatic test_overflow();
    logic [NR*DW-1:0] exp;
    drive({8'd0, 8'd0, 8'd230, 8'd30}, 4'b0010, 4'b0011);
    next_edge();
`ifdef ADDER_COLUMN_SAT_EN
    exp = {8'd0, 8'd0, 8'd255, 8'd30};
`else
    exp = {8'd0, 8'd0, 8'd4, 8'd30};
`endif
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL overflow: result=%h required=%h", result, exp);
    end
    // Overflow low in the chain, then carried up through two more stages.
    drive({8'd1, 8'd0, 8'd250, 8'd10}, 4'b1110, 4'b1111);
    next_edge();
`ifdef ADDER_COLUMN_SAT_EN
    exp = {8'd255, 8'd255, 8'd255, 8'd10};
`else
    exp = {8'd5, 8'd4, 8'd4, 8'd10};
`endif
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL overflow_propagate: result=%h required=%h", result, exp);
    end
  endtask

  task automatic test_boundaries();
    logic [NR*DW-1:0] exp;
    // No chaining at all: each row shows its own operand.
    drive({8'd1, 8'd2, 8'd3, 8'd4}, 4'b0000, 4'b1111);
    next_edge();
    exp = {8'd1, 8'd2, 8'd3, 8'd4};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL all_en_zero: result=%h required=%h", result, exp);
    end
    // Row 0 enable has nothing to add.
    drive({8'd1, 8'd2, 8'd3, 8'd4}, 4'b0001, 4'b1111);
    next_edge();
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL row0_en_ignored: result=%h required=%h", result, exp);
    end
    // Nothing visible: column is zero regardless of chaining.
    drive({8'd200, 8'd150, 8'd99, 8'd77}, 4'b1111, 4'b0000);
    next_edge();
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL all_vis_zero: result=%h required=%h", result, 32'h0);
    end
    // Chain broken at row 2: row 3 restarts from row 2's own operand.
    drive({8'd1, 8'd2, 8'd3, 8'd4}, 4'b1010, 4'b1111);
    next_edge();
    exp = {8'd3, 8'd2, 8'd7, 8'd4};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL chain_break: result=%h required=%h", result, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [NR*DW-1:0] data [3];
    logic [NR-1:0]    en   [3];
    logic [NR-1:0]    vis  [3];
    logic [NR*DW-1:0] exp  [3];
    data[0] = {8'd10, 8'd20, 8'd30, 8'd40}; en[0] = 4'b1110; vis[0] = 4'b1111;
    exp[0]  = {8'd100, 8'd90, 8'd70, 8'd40};
    data[1] = {8'd5, 8'd99, 8'd7, 8'd3};    en[1] = 4'b1110; vis[1] = 4'b1011;
    exp[1]  = {8'd15, 8'd10, 8'd10, 8'd3};
    data[2] = {8'd9, 8'd8, 8'd7, 8'd6};     en[2] = 4'b0100; vis[2] = 4'b0110;
    exp[2]  = {8'd0, 8'd15, 8'd7, 8'd0};
    for (int v = 0; v < 3; v++) begin
      drive(data[v], en[v], vis[v]);
      next_edge();
      compared++;
      if (result !== exp[v]) begin
        mismatched++;
        $display("FAIL back_to_back[%0d]: result=%h required=%h", v, result, exp[v]);
      end
    end
  endtask

  task automatic test_clear();
    logic [NR*DW-1:0] exp;
    drive('0, '0, '0);
    next_edge();
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL clear_inputs: result=%h required=%h", result, 32'h0);
    end
    drive({8'd10, 8'd20, 8'd30, 8'd40}, 4'b1110, 4'b1111);
    next_edge();
    exp = {8'd100, 8'd90, 8'd70, 8'd40};
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL clear_reload: result=%h required=%h", result, exp);
    end
    // Mid-cycle reset pulse must clear with no clock edge.
    #1;
    rst = 1'b0;
    #1;
    compared++;
    if (result !== '0) begin
      mismatched++;
      $display("FAIL midstream_reset: result=%h required=%h", result, 32'h0);
    end
    #1;
    rst = 1'b1;
    next_edge();
    compared++;
    if (result !== exp) begin
      mismatched++;
      $display("FAIL post_reset_reload: result=%h required=%h", result, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    drive('0, '0, '0);
    #2;
    test_reset();
    test_mixed();
    test_full_chain();
    test_pass_through();
    test_overflow();
    test_boundaries();
    test_back_to_back();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
